// File: rtl/fetch_pkg.sv
// fetch_pkg: shared width, entry type and instruction size for the fetch front end
package fetch_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_BYTES = 4;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush and combinational head
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic                   i_flush,
   input  fetch_entry_t           i_data,
   output logic [$clog2(DEPTH):0] o_count,
   output fetch_entry_t           o_head
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t r_mem [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [AW:0]   r_cnt;
   // storage and pointers; flush only rewinds pointers since stale data is masked by count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_mem[r_wr] <= i_data;
         r_wr  <= r_wr + AW'(i_push);
         r_rd  <= r_rd + AW'(i_pop);
         r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   assign o_count = r_cnt;
   assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch pc, in-flight tracking and credit control; FETCH_BUFFER_PERF_EN adds perf counters
module fetch_buffer #(
   parameter int              XLEN     = fetch_pkg::XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] mem_adr,
   output logic            mem_req,
   input  logic [XLEN-1:0] mem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr
`ifdef FETCH_BUFFER_PERF_EN
  ,output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall,
   output logic [31:0]     perf_flush
`endif
);
   import fetch_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;
   logic [XLEN-1:0] r_fetch_pc, r_inflight_pc;
   logic            r_inflight;
   logic [CW-1:0]   w_count;
   fetch_entry_t    w_head, w_push_data;
   logic            w_issue, w_push, w_pop, w_unused;
   // credit check counts the in-flight word so a capture never meets a full FIFO
   always_comb begin
      w_issue     = rst_n && !redirect_valid && (w_count + CW'(r_inflight) < CW'(DEPTH));
      w_push      = r_inflight && !redirect_valid;
      w_pop       = out_valid && out_ready && !redirect_valid;
      w_push_data = '{pc: r_inflight_pc, instr: mem_data};
   end
   // fetch pc and in-flight tracking; redirect discards the outstanding response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + XLEN'(INSTR_BYTES);
            r_inflight_pc <= r_fetch_pc;
         end
      end
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  (w_push_data),
      .o_count (w_count),
      .o_head  (w_head)
   );
   assign mem_req   = w_issue;
   assign mem_adr   = r_fetch_pc;
   assign out_valid = w_count != '0;
   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;
   assign w_unused  = ^redirect_pc[1:0];
`ifdef FETCH_BUFFER_PERF_EN
   logic [31:0] r_perf_fetched, r_perf_stall, r_perf_flush;
   // saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
         r_perf_flush   <= '0;
      end else begin
         if (w_push && !(&r_perf_fetched)) r_perf_fetched <= r_perf_fetched + 1'b1;
         if (out_valid && !out_ready && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 1'b1;
         if (redirect_valid && !(&r_perf_flush)) r_perf_flush <= r_perf_flush + 1'b1;
      end
   end
   assign perf_fetched = r_perf_fetched;
   assign perf_stall   = r_perf_stall;
   assign perf_flush   = r_perf_flush;
`endif
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: table-driven cycle checks of the fetch front end
module tb_fetch_buffer;
   logic        clk = 0, rst_n;
   logic [31:0] mem_adr, mem_data, redirect_pc, out_pc, out_instr;
   logic        mem_req, redirect_valid, out_valid, out_ready;
`ifdef FETCH_BUFFER_PERF_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif
   fetch_buffer dut (
      .clk(clk), .rst_n(rst_n), .mem_adr(mem_adr), .mem_req(mem_req), .mem_data(mem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_BUFFER_PERF_EN
     ,.perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
   );
   always #5 clk = ~clk;
   // memory word i is 32'h1000_0000 + i, returned one cycle after the address
   always @(posedge clk) mem_data <= 32'h1000_0000 + (mem_adr >> 2);
   typedef struct {
      bit rst; bit rdy; bit rv; logic [31:0] rpc;
      bit ev; logic [31:0] epc; bit ereq; logic [31:0] eadr;
   } vec_t;
   vec_t v [64];
   int n = 0, n_chk = 0, n_fail = 0;
   task automatic add(input bit rst, rdy, rv, input logic [31:0] rpc, input bit ev,
                      input logic [31:0] epc, input bit ereq, input logic [31:0] eadr);
      v[n] = '{rst, rdy, rv, rpc, ev, epc, ereq, eadr};
      n++;
   endtask
   task automatic chk(input string nm, input int i, input logic [31:0] g, e);
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h want %h", nm, i, g, e);
      end
   endtask
   task automatic run(input int i);
      @(posedge clk); #1;
      if (v[i].rst) begin rst_n = 0; #1; rst_n = 1; end
      out_ready = v[i].rdy; redirect_valid = v[i].rv; redirect_pc = v[i].rpc;
      @(negedge clk);
      chk("out_valid", i, 32'(out_valid), 32'(v[i].ev));
      chk("mem_req", i, 32'(mem_req), 32'(v[i].ereq));
      chk("mem_adr", i, mem_adr, v[i].eadr);
      if (v[i].ev) begin
         chk("out_pc", i, out_pc, v[i].epc);
         chk("out_instr", i, out_instr, 32'h1000_0000 + (v[i].epc >> 2));
      end
   endtask
   initial begin
      rst_n = 0; out_ready = 0; redirect_valid = 0; redirect_pc = 0;
      add(1,1,0,0, 0,0, 1,32'h0);
      add(0,1,0,0, 0,0, 1,32'h4);
      for (int k = 2; k <= 4; k++) add(0,1,0,0, 1,4*(k-2), 1,4*k);
      add(0,0,0,0, 1,32'hC, 1,32'h14);
      add(0,0,0,0, 1,32'hC, 1,32'h18);
      for (int k = 7; k <= 14; k++) add(0,0,0,0, 1,32'hC, 0,32'h1C);
      add(0,1,0,0, 1,32'hC, 0,32'h1C);
      add(0,1,0,0, 1,32'h10, 1,32'h1C);
      for (int k = 17; k <= 20; k++) add(0,1,0,0, 1,32'h14+4*(k-17), 1,32'h20+4*(k-17));
      add(1,1,0,0, 0,0, 1,32'h0);
      add(0,1,0,0, 0,0, 1,32'h4);
      for (int k = 2; k <= 5; k++) add(0,1,0,0, 1,4*(k-2), 1,4*k);
      add(0,1,1,32'h100, 1,32'h10, 0,32'h18);
      add(0,1,0,0, 0,0, 1,32'h100);
      add(0,1,0,0, 0,0, 1,32'h104);
      add(0,1,0,0, 1,32'h100, 1,32'h108);
      add(0,1,0,0, 1,32'h104, 1,32'h10C);
      add(0,1,1,32'h203, 1,32'h108, 0,32'h110);
      add(0,1,0,0, 0,0, 1,32'h200);
      add(0,1,0,0, 0,0, 1,32'h204);
      add(0,1,0,0, 1,32'h200, 1,32'h208);
      add(0,1,1,32'h40, 1,32'h204, 0,32'h20C);
      add(0,1,1,32'h80, 0,0, 0,32'h40);
      add(0,1,0,0, 0,0, 1,32'h80);
      add(0,1,0,0, 0,0, 1,32'h84);
      add(0,1,0,0, 1,32'h80, 1,32'h88);
      add(0,1,0,0, 1,32'h84, 1,32'h8C);
      add(0,0,0,0, 1,32'h88, 1,32'h90);
      add(0,0,0,0, 1,32'h88, 1,32'h94);
      add(0,0,0,0, 1,32'h88, 0,32'h98);
      add(0,0,0,0, 1,32'h88, 0,32'h98);
      add(0,0,1,32'h300, 1,32'h88, 0,32'h98);
      add(0,1,0,0, 0,0, 1,32'h300);
      add(0,1,0,0, 0,0, 1,32'h304);
      add(0,1,0,0, 1,32'h300, 1,32'h308);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", -1, 32'(out_valid), 0);
      chk("rst_req", -1, 32'(mem_req), 0);
      chk("rst_adr", -1, mem_adr, 0);
      chk("rst_pc", -1, out_pc, 0);
      chk("rst_instr", -1, out_instr, 0);
      for (int i = 0; i < n; i++) run(i);
      @(posedge clk); #1; out_ready = 0;
      @(negedge clk);
      chk("mid_valid", -2, 32'(out_valid), 1);
      chk("mid_pc", -2, out_pc, 32'h304);
      @(posedge clk); #1; rst_n = 0; #1;
      chk("async_valid", -3, 32'(out_valid), 0);
      chk("async_req", -3, 32'(mem_req), 0);
      chk("async_adr", -3, mem_adr, 0);
      chk("async_pc", -3, out_pc, 0);
      for (int i = 0; i <= 10; i++) run(i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch front end between the cpu decode stage and basic_mem.
- Drives the memory address each cycle and captures the returned instruction word.
- Queues (pc, instr) pairs in a small FIFO and hands them to decode over valid/ready.
- Handles redirects from execute by flushing queued and in-flight fetches.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_adr  out  XLEN  byte address to basic_mem; read data returns on mem_data exactly one cycle later.
- mem_req  out  1  a fetch is issued this cycle; mem_adr is don't-care when 0.
- mem_data  in  XLEN  instruction word for the address issued in the previous cycle.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  XLEN  pc of the head entry.
- out_instr  out  XLEN  instruction word of the head entry.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, inflight=0, out_valid=0, mem_req=0.
  - out_pc and out_instr reset to 0.
  - mem_adr reflects fetch_pc, so it equals RESET_PC during reset.
- Issue:
  - mem_req = !redirect_valid && (count + inflight < DEPTH).
  - mem_adr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN); inflight <= 1; inflight_pc <= fetch_pc.
  - With no issue, inflight <= 0.
- Capture: if inflight && !redirect_valid, push {inflight_pc, mem_data} into the FIFO that cycle.
  - The credit check guarantees a push never finds the FIFO full.
- Pop: when out_valid && out_ready, the head is removed. Push and pop in the same cycle are both allowed; count is unchanged.
- Outputs: out_valid = (count != 0). out_pc and out_instr come from the head entry.
- Latency after reset release:
  - Cycle 0: issue RESET_PC.
  - Cycle 1: capture.
  - Cycle 2: out_valid=1 with out_pc=RESET_PC.
- Steady-state throughput is 1 instruction/cycle while out_ready=1.
- Redirect in cycle t:
  - End of cycle t: FIFO cleared, inflight cleared, the response arriving in cycle t dropped, no issue in cycle t.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Cycle t+1: out_valid=0 and the new pc is issued.
  - Cycle t+3: out_valid=1 with out_pc=redirect_pc.
- Redirect takes priority over push and pop. A handshake on out in cycle t still completes from decode's view; the entry is flushed regardless.
- Back-to-back redirects: the last one wins, and nothing from the earlier target is ever output.
- Redirect while the FIFO is full, or while out_ready is held low, flushes identically.

Optional Feature:
- Macro FETCH_BUFFER_PERF_EN.
- When defined, the block adds outputs perf_fetched (32 bits), perf_stall (32 bits) and perf_flush (32 bits), all reset to 0 and saturating at all-ones:
  - perf_fetched counts pushes.
  - perf_stall counts cycles with out_valid && !out_ready.
  - perf_flush counts redirect cycles.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - XLEN default.
  - typedef fetch_entry_t, a struct of pc and instr.
  - constant INSTR_BYTES = 4.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t, parameterised by DEPTH.
  - Ports: push, pop, flush, count; head exposed combinationally.
- fetch_buffer holds the pc, in-flight and credit logic.

Test Plan:
- Reset release with RESET_PC=0, memory word i = 32'h1000_0000+i, out_ready=1:
  - out_valid rises in cycle 2.
  - out_pc sequence is 0,4,8,...; out_instr is 10000000,10000001,...
  - One instruction per cycle, none skipped or duplicated.
- out_ready=0 for 10 cycles:
  - FIFO fills to DEPTH=4 and mem_req drops to 0.
  - After out_ready=1, the order continues 0,4,8,C,10 with no loss.
- Redirect to 32'h100 in cycle 6 with out_ready=1:
  - out_valid=0 in cycles 7-8.
  - Cycle 9 gives out_pc=32'h100 and out_instr=mem[64].
  - No stale pc is ever output after the redirect.
- Redirect with redirect_pc=32'h203:
  - mem_adr=32'h200 next cycle; first out_pc=32'h200.
- Redirects in consecutive cycles to 32'h40 then 32'h80:
  - Only the 32'h80 stream appears.
- Reset asserted mid-stream with the FIFO half full:
  - out_valid=0 and mem_adr=RESET_PC immediately (async).
  - After release, the full reset sequence repeats.
